// File: rtl/axi_rt_pkg.sv
// Shared types for the real-time AXI budget controller: region state and overrun count.
// The overrun count type is only used when AXI_RT_BUDGET_OVERRUN_CNT_EN is defined.
package axi_rt_pkg;

  typedef enum logic {
    REGION_INACTIVE = 1'b0,
    REGION_ACTIVE   = 1'b1
  } region_state_e;

  typedef logic [7:0] overrun_cnt_t;

endpackage

// File: rtl/axi_rt_budget_region.sv
// One regulated region: period countdown, budget consumption and refill/carry-over.
// Optional macro AXI_RT_BUDGET_OVERRUN_CNT_EN adds a saturating count of spent_o rises.
module axi_rt_budget_region
  import axi_rt_pkg::*;
#(
  parameter int BudgetWidth = 32,
  parameter int PeriodWidth = 32,
  parameter int BytesWidth  = 12
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   enable_i,
  input  logic                   abort_i,
  input  logic                   hit_i,
  input  logic [BytesWidth-1:0]  bytes_i,
  input  logic [BudgetWidth-1:0] budget_i,
  input  logic [PeriodWidth-1:0] period_i,
  input  logic                   carry_i,
  output logic [BudgetWidth-1:0] budget_left_o,
  output logic [PeriodWidth-1:0] period_left_o,
  output logic                   spent_o,
  output region_state_e          state_o
`ifdef AXI_RT_BUDGET_OVERRUN_CNT_EN
  ,
  output overrun_cnt_t           overrun_cnt_o
`endif
);

  localparam int CmpWidth = (BudgetWidth > BytesWidth) ? BudgetWidth : BytesWidth;
  localparam logic [PeriodWidth-1:0] PeriodOne = PeriodWidth'(1);

  region_state_e          state_q, state_d;
  logic [BudgetWidth-1:0] budget_q, budget_d, after_ev;
  logic [PeriodWidth-1:0] period_q, period_d;
  logic [BudgetWidth:0]   carry_sum;
  logic                   spent_q, spent_d;

  always_comb begin
    state_d   = state_q;
    budget_d  = budget_q;
    period_d  = period_q;
    after_ev  = budget_q;
    if (hit_i) begin
      after_ev = (CmpWidth'(budget_q) > CmpWidth'(bytes_i)) ?
                 (budget_q - BudgetWidth'(bytes_i)) : '0;
    end
    // Refill sees the post-event budget; carry-over saturates at the counter maximum.
    carry_sum = {1'b0, after_ev} + {1'b0, budget_i};
    if (!enable_i) begin
      state_d  = REGION_INACTIVE;
      budget_d = '0;
      period_d = '0;
    end else if (state_q == REGION_INACTIVE || abort_i) begin
      state_d  = REGION_ACTIVE;
      budget_d = budget_i;
      period_d = period_i;
    end else if (period_q <= PeriodOne) begin
      period_d = period_i;
      if (!carry_i) begin
        budget_d = budget_i;
      end else if (carry_sum[BudgetWidth]) begin
        budget_d = '1;
      end else begin
        budget_d = carry_sum[BudgetWidth-1:0];
      end
    end else begin
      period_d = period_q - PeriodOne;
      budget_d = after_ev;
    end
    spent_d = (state_d == REGION_ACTIVE) && (budget_d == '0);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= REGION_INACTIVE;
      budget_q <= '0;
      period_q <= '0;
      spent_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      budget_q <= budget_d;
      period_q <= period_d;
      spent_q  <= spent_d;
    end
  end

  assign budget_left_o = budget_q;
  assign period_left_o = period_q;
  assign spent_o       = spent_q;
  assign state_o       = state_q;

`ifdef AXI_RT_BUDGET_OVERRUN_CNT_EN
  overrun_cnt_t overrun_q;

  always_ff @(posedge clk_i) begin
    if (rst_i || !enable_i || abort_i) begin
      overrun_q <= '0;
    end else if (spent_d && !spent_q && (overrun_q != 8'hFF)) begin
      overrun_q <= overrun_q + 8'd1;
    end
  end

  assign overrun_cnt_o = overrun_q;
`endif

endmodule

// File: rtl/axi_rt_budget_ctrl.sv
// Per-region bandwidth regulator for AXI address handshakes; decodes events onto regions.
// Optional macro AXI_RT_BUDGET_OVERRUN_CNT_EN exposes per-region overrun counters.
module axi_rt_budget_ctrl
  import axi_rt_pkg::*;
#(
  parameter int NumRegions  = 4,
  parameter int BudgetWidth = 32,
  parameter int PeriodWidth = 32,
  parameter int BytesWidth  = 12,
  localparam int RegionWidth = (NumRegions > 1) ? $clog2(NumRegions) : 1
) (
  input  logic                              clk_i,
  input  logic                              rst_i,
  input  logic                              enable_i,
  input  logic                              abort_i,
  input  logic                              ev_valid_i,
  input  logic [RegionWidth-1:0]            ev_region_i,
  input  logic [BytesWidth-1:0]             ev_bytes_i,
  input  logic [NumRegions*BudgetWidth-1:0] budget_i,
  input  logic [NumRegions*PeriodWidth-1:0] period_i,
  input  logic [NumRegions-1:0]             carry_i,
  output logic [NumRegions*BudgetWidth-1:0] budget_left_o,
  output logic [NumRegions*PeriodWidth-1:0] period_left_o,
  output logic [NumRegions-1:0]             spent_o,
  output logic                              ev_drop_o
`ifdef AXI_RT_BUDGET_OVERRUN_CNT_EN
  ,
  output logic [NumRegions*8-1:0]           overrun_cnt_o
`endif
);

  region_state_e          state [NumRegions];
  logic [NumRegions-1:0]  hit;
  logic                   out_of_range;
  logic                   drop_q;

  // Compare one bit wider so NumRegions itself is representable.
  assign out_of_range = {1'b0, ev_region_i} >= (RegionWidth + 1)'(NumRegions);

  for (genvar r = 0; r < NumRegions; r++) begin : g_region
    // Only an ACTIVE region consumes budget from an event.
    assign hit[r] = ev_valid_i && (ev_region_i == RegionWidth'(r)) &&
                    (state[r] == REGION_ACTIVE);

    axi_rt_budget_region #(
      .BudgetWidth (BudgetWidth),
      .PeriodWidth (PeriodWidth),
      .BytesWidth  (BytesWidth)
    ) u_region (
      .clk_i         (clk_i),
      .rst_i         (rst_i),
      .enable_i      (enable_i),
      .abort_i       (abort_i),
      .hit_i         (hit[r]),
      .bytes_i       (ev_bytes_i),
      .budget_i      (budget_i[r*BudgetWidth +: BudgetWidth]),
      .period_i      (period_i[r*PeriodWidth +: PeriodWidth]),
      .carry_i       (carry_i[r]),
      .budget_left_o (budget_left_o[r*BudgetWidth +: BudgetWidth]),
      .period_left_o (period_left_o[r*PeriodWidth +: PeriodWidth]),
      .spent_o       (spent_o[r]),
      .state_o       (state[r])
`ifdef AXI_RT_BUDGET_OVERRUN_CNT_EN
      ,
      .overrun_cnt_o (overrun_cnt_o[r*8 +: 8])
`endif
    );
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      drop_q <= 1'b0;
    end else begin
      drop_q <= ev_valid_i && out_of_range;
    end
  end

  assign ev_drop_o = drop_q;

endmodule
